// File: rtl/ysyx_22050078_lsu_ctrl_if.sv
// Bundle of the LSU upstream, data-memory and writeback ports.
// Signal names keep the LSU's point of view: i_* flow into the LSU, o_* flow out of it.
interface ysyx_22050078_lsu_ctrl_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned OP_W   = 4
);
    // Upstream (execute) side
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_exu_res;
    logic [DATA_W-1:0] i_rs2_data;
    logic [OP_W-1:0]   i_lsu_op;
    logic [4:0]        i_rd_idx;
    logic              i_rd_wen;

    // Data-memory port
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [7:0]        o_mem_wmask;
    logic              i_mem_gnt;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    // Writeback side
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_wb_data;
    logic [4:0]        o_rd_idx;
    logic              o_rd_wen;
    logic              o_misalign;

    // The LSU itself
    modport slave (
        input  i_valid, i_exu_res, i_rs2_data, i_lsu_op, i_rd_idx, i_rd_wen,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output o_valid, o_wb_data, o_rd_idx, o_rd_wen, o_misalign
    );

    // Whatever drives the LSU (pipeline + memory + WB)
    modport master (
        output i_valid, i_exu_res, i_rs2_data, i_lsu_op, i_rd_idx, i_rd_wen,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  o_valid, o_wb_data, o_rd_idx, o_rd_wen, o_misalign
    );
endinterface

// File: rtl/ysyx_22050078_lsu_ctrl.sv
// Non-pipelined load/store stage: one execute result in, at most one data-memory
// transaction, one writeback result out. Loads are lane-aligned and sign/zero-extended,
// stores are shifted into their byte lanes, misaligned H/W/D accesses fault without
// touching memory.
module ysyx_22050078_lsu_ctrl #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned OP_W   = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    ysyx_22050078_lsu_ctrl_if.slave bus
);
    localparam logic [OP_W-1:0] OpLb  = OP_W'(1);
    localparam logic [OP_W-1:0] OpLh  = OP_W'(2);
    localparam logic [OP_W-1:0] OpLw  = OP_W'(3);
    localparam logic [OP_W-1:0] OpLd  = OP_W'(4);
    localparam logic [OP_W-1:0] OpLbu = OP_W'(5);
    localparam logic [OP_W-1:0] OpLhu = OP_W'(6);
    localparam logic [OP_W-1:0] OpLwu = OP_W'(7);
    localparam logic [OP_W-1:0] OpSb  = OP_W'(8);
    localparam logic [OP_W-1:0] OpSh  = OP_W'(9);
    localparam logic [OP_W-1:0] OpSw  = OP_W'(10);
    localparam logic [OP_W-1:0] OpSd  = OP_W'(11);

    // Access size encoding
    localparam logic [1:0] SzB = 2'd0;
    localparam logic [1:0] SzH = 2'd1;
    localparam logic [1:0] SzW = 2'd2;
    localparam logic [1:0] SzD = 2'd3;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return (op >= OpLb) && (op <= OpLwu);
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op >= OpSb) && (op <= OpSd);
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        case (op)
            OpLh, OpLhu, OpSh: sz = SzH;
            OpLw, OpLwu, OpSw: sz = SzW;
            OpLd, OpSd:        sz = SzD;
            default:           sz = SzB;
        endcase
        return sz;
    endfunction

    // FSM state and registered outputs
    state_e            state_q;
    logic [OP_W-1:0]   op_q;
    logic [2:0]        addr_lo_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [7:0]        mem_wmask_q;
    logic              valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        rd_idx_q;
    logic              rd_wen_q;
    logic              misalign_q;

    // Decode of the incoming op (only meaningful in IDLE)
    logic              in_load;
    logic              in_store;
    logic              in_misalign;
    logic [2:0]        in_lo;
    logic [DATA_W-1:0] in_wdata;
    logic [7:0]        in_wmask;

    // Decode the op presented by execute: class, alignment, store lanes
    always_comb begin
        in_load     = op_is_load(bus.i_lsu_op);
        in_store    = op_is_store(bus.i_lsu_op);
        in_lo       = bus.i_exu_res[2:0];
        in_misalign = 1'b0;
        in_wmask    = 8'h00;
        in_wdata    = '0;
        case (op_size(bus.i_lsu_op))
            SzH:     in_misalign = in_lo[0];
            SzW:     in_misalign = |in_lo[1:0];
            SzD:     in_misalign = |in_lo;
            default: in_misalign = 1'b0;
        endcase
        if (in_store) begin
            in_wdata = bus.i_rs2_data << {in_lo, 3'b000};
            case (op_size(bus.i_lsu_op))
                SzB:     in_wmask = 8'h01 << in_lo;
                SzH:     in_wmask = 8'h03 << in_lo;
                SzW:     in_wmask = 8'h0F << in_lo;
                default: in_wmask = 8'hFF;
            endcase
        end
    end

    // Load data: select the addressed lane and extend according to the captured op
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        ld_shift = bus.i_mem_rdata >> {addr_lo_q, 3'b000};
        case (op_q)
            OpLb:    ld_data = {{(DATA_W-8){ld_shift[7]}}, ld_shift[7:0]};
            OpLh:    ld_data = {{(DATA_W-16){ld_shift[15]}}, ld_shift[15:0]};
            OpLw:    ld_data = {{(DATA_W-32){ld_shift[31]}}, ld_shift[31:0]};
            OpLbu:   ld_data = {{(DATA_W-8){1'b0}}, ld_shift[7:0]};
            OpLhu:   ld_data = {{(DATA_W-16){1'b0}}, ld_shift[15:0]};
            OpLwu:   ld_data = {{(DATA_W-32){1'b0}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Transaction FSM with all outputs registered; reset abandons any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            addr_lo_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            valid_q     <= 1'b0;
            wb_data_q   <= '0;
            rd_idx_q    <= '0;
            rd_wen_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_valid) begin
                        op_q       <= bus.i_lsu_op;
                        addr_lo_q  <= in_lo;
                        rd_idx_q   <= bus.i_rd_idx;
                        misalign_q <= 1'b0;
                        if (!in_load && !in_store) begin
                            // Pass-through: result is ready straight away
                            wb_data_q <= bus.i_exu_res;
                            rd_wen_q  <= bus.i_rd_wen;
                            valid_q   <= 1'b1;
                            state_q   <= StResp;
                        end else if (in_misalign) begin
                            // Fault: report the address, never touch memory
                            wb_data_q  <= bus.i_exu_res;
                            rd_wen_q   <= 1'b0;
                            misalign_q <= 1'b1;
                            valid_q    <= 1'b1;
                            state_q    <= StResp;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_store;
                            mem_addr_q  <= {bus.i_exu_res[ADDR_W-1:3], 3'b000};
                            mem_wdata_q <= in_wdata;
                            mem_wmask_q <= in_wmask;
                            rd_wen_q    <= in_store ? 1'b0 : bus.i_rd_wen;
                            state_q     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (bus.i_mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        if (mem_we_q) begin
                            wb_data_q <= '0;
                            rd_wen_q  <= 1'b0;
                            valid_q   <= 1'b1;
                            state_q   <= StResp;
                        end else if (bus.i_mem_rvalid) begin
                            // Zero-latency memory: data arrives with the grant
                            wb_data_q <= ld_data;
                            valid_q   <= 1'b1;
                            state_q   <= StResp;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.i_mem_rvalid) begin
                        wb_data_q <= ld_data;
                        valid_q   <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready is a pure state decode so it reads 1 throughout reset
    assign bus.o_ready     = (state_q == StIdle);
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_wmask = mem_wmask_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_wb_data   = wb_data_q;
    assign bus.o_rd_idx    = rd_idx_q;
    assign bus.o_rd_wen    = rd_wen_q;
    assign bus.o_misalign  = misalign_q;
endmodule

// File: tb/tb_ysyx_22050078_lsu_ctrl.sv
// Directed bench for the load/store stage: loads with late grant/rvalid, lane
// extraction and extension, store lanes/masks, misalignment fault, WB back-pressure
// and reset in the middle of a load.
module tb_ysyx_22050078_lsu_ctrl;
    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_fail;

    ysyx_22050078_lsu_ctrl_if bus ();

    ysyx_22050078_lsu_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Present one op for a single cycle starting at a negedge; returns at the next negedge
    task automatic issue(input logic [3:0] op, input logic [63:0] res, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic wen);
        bus.i_valid    = 1'b1;
        bus.i_lsu_op   = op;
        bus.i_exu_res  = res;
        bus.i_rs2_data = rs2;
        bus.i_rd_idx   = rd;
        bus.i_rd_wen   = wen;
        @(negedge clk);
        bus.i_valid    = 1'b0;
        bus.i_lsu_op   = 4'd0;
    endtask

    // Load with grant and data in the same cycle; checks the extended result
    task automatic load_fast(input string tag, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] rdata, input logic [63:0] exp);
        issue(op, a, 64'd0, 5'd3, 1'b1);
        check_eq({tag, "_req"}, 64'(bus.o_mem_req), 64'd1);
        check_eq({tag, "_addr"}, bus.o_mem_addr, {a[63:3], 3'b000});
        bus.i_mem_gnt    = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rdata;
        @(negedge clk);
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
        check_eq({tag, "_data"}, bus.o_wb_data, exp);
        @(negedge clk);
    endtask

    // Store with immediate grant; checks lanes, mask and the no-writeback result
    task automatic store_fast(input string tag, input logic [3:0] op, input logic [63:0] a,
                              input logic [63:0] rs2, input logic [63:0] exp_wdata,
                              input logic [7:0] exp_mask);
        issue(op, a, rs2, 5'd9, 1'b1);
        check_eq({tag, "_we"}, 64'(bus.o_mem_we), 64'd1);
        check_eq({tag, "_addr"}, bus.o_mem_addr, {a[63:3], 3'b000});
        check_eq({tag, "_mask"}, 64'(bus.o_mem_wmask), 64'(exp_mask));
        check_eq({tag, "_wdata"}, bus.o_mem_wdata, exp_wdata);
        bus.i_mem_gnt = 1'b1;
        @(negedge clk);
        bus.i_mem_gnt = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
        check_eq({tag, "_rdwen"}, 64'(bus.o_rd_wen), 64'd0);
        check_eq({tag, "_req_drop"}, 64'(bus.o_mem_req), 64'd0);
        check_eq({tag, "_mask_drop"}, 64'(bus.o_mem_wmask), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_exu_res    = '0;
        bus.i_rs2_data   = '0;
        bus.i_lsu_op     = '0;
        bus.i_rd_idx     = '0;
        bus.i_rd_wen     = 1'b0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.i_ready      = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(bus.o_ready), 64'd1);
        check_eq("rst_valid", 64'(bus.o_valid), 64'd0);
        check_eq("rst_req", 64'(bus.o_mem_req), 64'd0);
        check_eq("rst_wb", bus.o_wb_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LD with grant two cycles late and data one cycle after grant
        issue(4'd4, 64'h8000_0010, 64'd0, 5'd7, 1'b1);
        check_eq("ld_req", 64'(bus.o_mem_req), 64'd1);
        check_eq("ld_addr", bus.o_mem_addr, 64'h8000_0010);
        check_eq("ld_ready_busy", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        check_eq("ld_req_hold", 64'(bus.o_mem_req), 64'd1);
        check_eq("ld_addr_hold", bus.o_mem_addr, 64'h8000_0010);
        @(negedge clk);
        bus.i_mem_gnt = 1'b1;
        @(negedge clk);
        bus.i_mem_gnt = 1'b0;
        check_eq("ld_wait_req", 64'(bus.o_mem_req), 64'd0);
        check_eq("ld_wait_valid", 64'(bus.o_valid), 64'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 64'h1122_3344_5566_7788;
        @(negedge clk);
        bus.i_mem_rvalid = 1'b0;
        check_eq("ld_valid", 64'(bus.o_valid), 64'd1);
        check_eq("ld_data", bus.o_wb_data, 64'h1122_3344_5566_7788);
        check_eq("ld_rdwen", 64'(bus.o_rd_wen), 64'd1);
        check_eq("ld_rdidx", 64'(bus.o_rd_idx), 64'd7);
        check_eq("ld_misalign", 64'(bus.o_misalign), 64'd0);
        @(negedge clk);
        check_eq("ld_valid_drop", 64'(bus.o_valid), 64'd0);
        check_eq("ld_ready_back", 64'(bus.o_ready), 64'd1);

        // Lane extraction and extension
        load_fast("lb", 4'd1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        load_fast("lbu", 4'd5, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        load_fast("lw", 4'd3, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        load_fast("lwu", 4'd7, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
        load_fast("lh", 4'd2, 64'h8000_0002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
        load_fast("lhu", 4'd6, 64'h8000_0002, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);

        // Store lanes and masks
        store_fast("sh", 4'd9, 64'h8000_0006, 64'h0000_0000_0000_ABCD,
                   64'hABCD_0000_0000_0000, 8'hC0);
        store_fast("sb", 4'd8, 64'h8000_0005, 64'h0000_0000_0000_005A,
                   64'h0000_5A00_0000_0000, 8'h20);
        store_fast("sw", 4'd10, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF,
                   64'hDEAD_BEEF_0000_0000, 8'hF0);
        store_fast("sd", 4'd11, 64'h8000_0008, 64'h0102_0304_0506_0708,
                   64'h0102_0304_0506_0708, 8'hFF);

        // Misaligned word: fault with the address, no memory request
        issue(4'd3, 64'h8000_0002, 64'd0, 5'd4, 1'b1);
        check_eq("mis_req", 64'(bus.o_mem_req), 64'd0);
        check_eq("mis_valid", 64'(bus.o_valid), 64'd1);
        check_eq("mis_flag", 64'(bus.o_misalign), 64'd1);
        check_eq("mis_wb", bus.o_wb_data, 64'h8000_0002);
        check_eq("mis_rdwen", 64'(bus.o_rd_wen), 64'd0);
        @(negedge clk);

        // Pass-through with WB back-pressure
        bus.i_ready = 1'b0;
        issue(4'd0, 64'h1234, 64'd0, 5'd12, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("none_valid%0d", i), 64'(bus.o_valid), 64'd1);
            check_eq($sformatf("none_wb%0d", i), bus.o_wb_data, 64'h1234);
            check_eq($sformatf("none_rdidx%0d", i), 64'(bus.o_rd_idx), 64'd12);
            check_eq($sformatf("none_ready%0d", i), 64'(bus.o_ready), 64'd0);
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        check_eq("none_rdwen", 64'(bus.o_rd_wen), 64'd1);
        @(negedge clk);
        check_eq("none_valid_drop", 64'(bus.o_valid), 64'd0);
        check_eq("none_ready_back", 64'(bus.o_ready), 64'd1);

        // Reset while waiting for load data
        issue(4'd4, 64'h8000_0020, 64'd0, 5'd1, 1'b1);
        bus.i_mem_gnt = 1'b1;
        @(negedge clk);
        bus.i_mem_gnt = 1'b0;
        check_eq("rw_wait_req", 64'(bus.o_mem_req), 64'd0);
        check_eq("rw_wait_ready", 64'(bus.o_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rw_req", 64'(bus.o_mem_req), 64'd0);
        check_eq("rw_valid", 64'(bus.o_valid), 64'd0);
        check_eq("rw_ready", 64'(bus.o_ready), 64'd1);
        @(negedge clk);
        rst_n            = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        bus.i_mem_rvalid = 1'b0;
        check_eq("rw_late_valid", 64'(bus.o_valid), 64'd0);
        check_eq("rw_late_ready", 64'(bus.o_ready), 64'd1);
        load_fast("rw_next", 4'd4, 64'h8000_0028, 64'hCAFE_F00D_1234_5678,
                  64'hCAFE_F00D_1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
